// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: widths, funct3 codes,
// FSM states and the latched request descriptor.
package mem_ctrl_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned CNT_W  = 3;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  localparam logic [WORD_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic              is_if;
    logic [F3_W-1:0]   width;
    logic [CNT_W-1:0]  nbytes;
  } req_t;

  // Bytes per access: x00 -> 1, x01 -> 2, anything else is a word.
  function automatic logic [CNT_W-1:0] byte_count(input logic [F3_W-1:0] width);
    case (width[1:0])
      2'b00:   return CNT_W'(1);
      2'b01:   return CNT_W'(2);
      default: return CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_ext.sv
// Load-data extension: sign- or zero-extends a byte/half, passes words through.
module mem_ext
  import mem_ctrl_pkg::*;
(
  input  logic [F3_W-1:0]   width,
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] ext_c
);

  always_comb begin
    ext_c = word;
    case (width)
      F3_LB:   ext_c = {{24{word[7]}}, word[7:0]};
      F3_LH:   ext_c = {{16{word[15]}}, word[15:0]};
      F3_LBU:  ext_c = {24'b0, word[7:0]};
      F3_LHU:  ext_c = {16'b0, word[15:0]};
      default: ext_c = word;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM port between instruction fetch and the MEM load/store
// path, serialising each access into byte transfers.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic              if_done,
  output logic [WORD_W-1:0] if_data,
  input  logic              ma_re,
  input  logic              ma_we,
  input  logic [F3_W-1:0]   ma_width,
  input  logic [WORD_W-1:0] ma_addr,
  input  logic [WORD_W-1:0] ma_wdata,
  output logic              ma_done,
  output logic [WORD_W-1:0] ma_rdata,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  output logic [ADDR_W-1:0] mem_a,
  output logic [BYTE_W-1:0] mem_dout,
  input  logic [BYTE_W-1:0] mem_din,
  output logic              mem_wr
);

  state_t              state_q, state_d;
  req_t                req_q, req_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   a_d;
  logic [BYTE_W-1:0]   dout_d;
  logic                if_done_d, ma_done_d;
  logic [WORD_W-1:0]   if_data_d, ma_rdata_d;
  logic [WORD_W-1:0]   word_c, ext_c;
  logic [CNT_W-1:0]    cnt_inc_c;

  assign stallreq_if  = if_req & ~if_done;
  assign stallreq_mem = (ma_re | ma_we) & ~ma_done;
  assign mem_wr       = wr_q & rdy;
  assign cnt_inc_c    = cnt_q + CNT_W'(1);

  // Read buffer with the byte arriving this cycle merged into lane cnt-1.
  always_comb begin
    word_c = buf_q;
    case (cnt_q)
      3'd1:    word_c[7:0]   = mem_din;
      3'd2:    word_c[15:8]  = mem_din;
      3'd3:    word_c[23:16] = mem_din;
      3'd4:    word_c[31:24] = mem_din;
      default: word_c = buf_q;
    endcase
  end

  mem_ext u_ext (
    .width (req_q.width),
    .word  (word_c),
    .ext_c (ext_c)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    wr_d       = wr_q;
    a_d        = mem_a;
    dout_d     = mem_dout;
    if_done_d  = if_done;
    if_data_d  = if_data;
    ma_done_d  = ma_done;
    ma_rdata_d = ma_rdata;
    if (rdy) begin
      if_done_d = 1'b0;
      ma_done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          buf_d = ZERO_WORD;
          if (ma_re || ma_we) begin
            req_d = '{is_if: 1'b0, width: ma_width, nbytes: byte_count(ma_width)};
            a_d   = ADDR_W'(ma_addr);
            if (ma_we) begin
              state_d = ST_WRITE;
              wr_d    = 1'b1;
              wdata_d = ma_wdata;
              dout_d  = ma_wdata[7:0];
            end else begin
              state_d = ST_READ;
            end
          end else if (if_req) begin
            req_d   = '{is_if: 1'b1, width: F3_LW, nbytes: CNT_W'(4)};
            a_d     = ADDR_W'(if_addr);
            state_d = ST_READ;
          end
        end
        // Addresses go out while cnt < n; byte for lane cnt-1 lands one cycle later.
        ST_READ: begin
          if (cnt_q != '0) buf_d = word_c;
          if (cnt_q == req_q.nbytes) begin
            state_d = ST_DONE;
            if (req_q.is_if) begin
              if_done_d = 1'b1;
              if_data_d = word_c;
            end else begin
              ma_done_d  = 1'b1;
              ma_rdata_d = ext_c;
            end
          end else begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c < req_q.nbytes) a_d = mem_a + ADDR_W'(1);
          end
        end
        ST_WRITE: begin
          if (cnt_inc_c < req_q.nbytes) begin
            cnt_d   = cnt_inc_c;
            a_d     = mem_a + ADDR_W'(1);
            dout_d  = wdata_q[15:8];
            wdata_d = wdata_q >> 8;
          end else begin
            wr_d      = 1'b0;
            state_d   = ST_DONE;
            ma_done_d = 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      cnt_q    <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      wr_q     <= 1'b0;
      mem_a    <= '0;
      mem_dout <= '0;
      if_done  <= 1'b0;
      if_data  <= '0;
      ma_done  <= 1'b0;
      ma_rdata <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      wr_q     <= wr_d;
      mem_a    <= a_d;
      mem_dout <= dout_d;
      if_done  <= if_done_d;
      if_data  <= if_data_d;
      ma_done  <= ma_done_d;
      ma_rdata <= ma_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: fetch, loads with extension, stores, arbitration,
// rdy freeze, async reset abort and address wrap against a one-cycle-latency RAM.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        ma_re, ma_we, ma_done;
  logic [2:0]  ma_width;
  logic [31:0] ma_addr, ma_wdata, ma_rdata;
  logic        stallreq_if, stallreq_mem;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, mem_din;
  logic        mem_wr;

  logic [7:0]  ram [0:4095];
  logic [31:0] addr_log [0:15];
  logic        wr_log [0:15];
  logic [7:0]  dout_log [0:15];
  logic        sif_log [0:15];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ma_re(ma_re), .ma_we(ma_we), .ma_width(ma_width), .ma_addr(ma_addr),
    .ma_wdata(ma_wdata), .ma_done(ma_done), .ma_rdata(ma_rdata),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_din(mem_din), .mem_wr(mem_wr)
  );

  // RAM: read data one cycle after the address, write on the strobe.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[11:0]];
    if (mem_wr) ram[mem_a[11:0]] = mem_dout;
  end

  task automatic wait_done(input bit want_if, input int max_cyc, output int cyc);
    cyc = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(posedge clk); #1;
      addr_log[k] = mem_a;
      wr_log[k]   = mem_wr;
      dout_log[k] = mem_dout;
      sif_log[k]  = stallreq_if;
      if ((want_if ? if_done : ma_done) === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic start_mem(input bit we, input logic [2:0] w, input logic [31:0] a,
                           input logic [31:0] d);
    @(posedge clk); #1;
    ma_we = we; ma_re = ~we; ma_width = w; ma_addr = a; ma_wdata = d;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (mem_a !== 32'h0) begin n_err++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
    n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
    n_cmp++; if (mem_dout !== 8'h0) begin n_err++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout); end
    n_cmp++; if ({if_done, ma_done} !== 2'b00) begin n_err++; $display("FAIL reset_done: got %b want 00", {if_done, ma_done}); end
    n_cmp++; if (if_data !== 32'h0) begin n_err++; $display("FAIL reset_if_data: got %h want 0", if_data); end
    n_cmp++; if (ma_rdata !== 32'h0) begin n_err++; $display("FAIL reset_ma_rdata: got %h want 0", ma_rdata); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_lw_fetch;
    int cyc;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h00; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    n_cmp++; if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL fetch_stall_c0: got %b want 1", stallreq_if); end
    wait_done(1'b1, 10, cyc);
    n_cmp++; if (cyc !== 6) begin n_err++; $display("FAIL fetch_done_cycle: got %0d want 6", cyc); end
    for (int k = 1; k <= 4; k++) begin
      n_cmp++;
      if (addr_log[k] !== 32'h100 + 32'(k - 1) || wr_log[k] !== 1'b0) begin
        n_err++; $display("FAIL fetch_addr_c%0d: got %h wr %b want %h wr 0", k, addr_log[k], wr_log[k], 32'h100 + 32'(k - 1));
      end
    end
    n_cmp++; if (if_data !== 32'h0000_0013) begin n_err++; $display("FAIL fetch_data: got %h want 00000013", if_data); end
    n_cmp++; if (stallreq_if !== 1'b0) begin n_err++; $display("FAIL fetch_stall_done: got %b want 0", stallreq_if); end
    if_req = 1'b0;
  endtask

  task automatic test_load_ext;
    int cyc;
    logic [2:0]  w_v   [0:3] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] a_v   [0:3] = '{32'h20, 32'h20, 32'h30, 32'h30};
    logic [31:0] exp_v [0:3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_9234, 32'h0000_9234};
    int          lat_v [0:3] = '{3, 3, 4, 4};
    ram[12'h020] = 8'h80; ram[12'h021] = 8'h7F;
    ram[12'h030] = 8'h34; ram[12'h031] = 8'h92; ram[12'h032] = 8'h55;
    for (int t = 0; t < 4; t++) begin
      start_mem(1'b0, w_v[t], a_v[t], 32'h0);
      wait_done(1'b0, 10, cyc);
      n_cmp++; if (cyc !== lat_v[t]) begin n_err++; $display("FAIL load%0d_done_cycle: got %0d want %0d", t, cyc, lat_v[t]); end
      n_cmp++; if (ma_rdata !== exp_v[t]) begin n_err++; $display("FAIL load%0d_rdata: got %h want %h", t, ma_rdata, exp_v[t]); end
      ma_re = 1'b0;
    end
  endtask

  task automatic test_store_half;
    int cyc;
    ram[12'h040] = 8'h11; ram[12'h041] = 8'h22; ram[12'h042] = 8'h33;
    start_mem(1'b1, 3'b001, 32'h40, 32'hDEAD_BEEF);
    wait_done(1'b0, 10, cyc);
    n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL sh_done_cycle: got %0d want 3", cyc); end
    n_cmp++;
    if ({wr_log[1], addr_log[1], dout_log[1]} !== {1'b1, 32'h40, 8'hEF}) begin
      n_err++; $display("FAIL sh_byte0: got wr %b a %h d %h want 1 40 EF", wr_log[1], addr_log[1], dout_log[1]);
    end
    n_cmp++;
    if ({wr_log[2], addr_log[2], dout_log[2]} !== {1'b1, 32'h41, 8'hBE}) begin
      n_err++; $display("FAIL sh_byte1: got wr %b a %h d %h want 1 41 BE", wr_log[2], addr_log[2], dout_log[2]);
    end
    n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL sh_wr_done: got %b want 0", mem_wr); end
    n_cmp++;
    if ({ram[12'h042], ram[12'h041], ram[12'h040]} !== 24'h33BEEF) begin
      n_err++; $display("FAIL sh_ram: got %h want 33BEEF", {ram[12'h042], ram[12'h041], ram[12'h040]});
    end
    n_cmp++; if (ma_rdata !== 32'h0000_9234) begin n_err++; $display("FAIL sh_rdata_hold: got %h want 00009234", ma_rdata); end
    ma_we = 1'b0;
  endtask

  task automatic test_contention;
    int  cyc;
    logic all_high;
    ram[12'h200] = 8'h11; ram[12'h201] = 8'h22; ram[12'h202] = 8'h33; ram[12'h203] = 8'h44;
    ram[12'h300] = 8'h93; ram[12'h301] = 8'h00; ram[12'h302] = 8'h50; ram[12'h303] = 8'h00;
    start_mem(1'b0, 3'b010, 32'h200, 32'h0);
    if_req = 1'b1; if_addr = 32'h300;
    wait_done(1'b0, 10, cyc);
    n_cmp++; if (cyc !== 6) begin n_err++; $display("FAIL arb_mem_cycle: got %0d want 6", cyc); end
    n_cmp++; if (ma_rdata !== 32'h4433_2211) begin n_err++; $display("FAIL arb_mem_data: got %h want 44332211", ma_rdata); end
    n_cmp++; if (addr_log[1] !== 32'h200) begin n_err++; $display("FAIL arb_first_addr: got %h want 200", addr_log[1]); end
    all_high = 1'b1;
    for (int k = 1; k <= 6; k++) all_high &= sif_log[k];
    n_cmp++; if (all_high !== 1'b1) begin n_err++; $display("FAIL arb_stall_if: got %b want 1", all_high); end
    ma_re = 1'b0;
    wait_done(1'b1, 12, cyc);
    n_cmp++; if (cyc !== 7) begin n_err++; $display("FAIL arb_if_cycle: got %0d want 7", cyc); end
    n_cmp++; if (addr_log[2] !== 32'h300 || addr_log[5] !== 32'h303) begin
      n_err++; $display("FAIL arb_if_addr: got %h..%h want 300..303", addr_log[2], addr_log[5]);
    end
    n_cmp++; if (if_data !== 32'h0050_0093) begin n_err++; $display("FAIL arb_if_data: got %h want 00500093", if_data); end
    if_req = 1'b0;
  endtask

  task automatic test_rdy_freeze;
    int cyc;
    start_mem(1'b1, 3'b010, 32'h500, 32'hCAFE_F00D);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rdy = 1'b0;
    for (int f = 0; f < 3; f++) begin
      if (f != 0) begin @(posedge clk); #1; end
      #1;
      n_cmp++;
      if (mem_wr !== 1'b0 || mem_a !== 32'h501) begin
        n_err++; $display("FAIL freeze_f%0d: got wr %b a %h want 0 501", f, mem_wr, mem_a);
      end
    end
    @(posedge clk); #1;
    rdy = 1'b1;
    #1;
    n_cmp++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h501 || mem_dout !== 8'hF0) begin
      n_err++; $display("FAIL freeze_resume: got wr %b a %h d %h want 1 501 F0", mem_wr, mem_a, mem_dout);
    end
    wait_done(1'b0, 10, cyc);
    n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL freeze_done_cycle: got %0d want 3", cyc); end
    n_cmp++;
    if ({ram[12'h503], ram[12'h502], ram[12'h501], ram[12'h500]} !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL freeze_ram: got %h want CAFEF00D", {ram[12'h503], ram[12'h502], ram[12'h501], ram[12'h500]});
    end
    ma_we = 1'b0;
  endtask

  task automatic test_reset_abort;
    int cyc;
    for (int i = 0; i < 4; i++) ram[12'h600 + i] = 8'hAA;
    start_mem(1'b1, 3'b010, 32'h600, 32'h1234_5678);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL abort_wr: got %b want 0", mem_wr); end
    n_cmp++; if (mem_a !== 32'h0 || if_data !== 32'h0) begin n_err++; $display("FAIL abort_regs: got a %h ifd %h want 0 0", mem_a, if_data); end
    ma_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_cmp++;
    if ({ram[12'h602], ram[12'h601], ram[12'h600]} !== 24'hAAAA78) begin
      n_err++; $display("FAIL abort_ram: got %h want AAAA78", {ram[12'h602], ram[12'h601], ram[12'h600]});
    end
    start_mem(1'b0, 3'b010, 32'h600, 32'h0);
    wait_done(1'b0, 10, cyc);
    n_cmp++; if (cyc !== 6) begin n_err++; $display("FAIL abort_lw_cycle: got %0d want 6", cyc); end
    n_cmp++; if (ma_rdata !== 32'hAAAA_AA78) begin n_err++; $display("FAIL abort_lw_data: got %h want AAAAAA78", ma_rdata); end
    ma_re = 1'b0;
  endtask

  task automatic test_wrap;
    int cyc;
    ram[12'hFFE] = 8'h01; ram[12'hFFF] = 8'h02; ram[12'h000] = 8'h03; ram[12'h001] = 8'h04;
    start_mem(1'b0, 3'b011, 32'hFFFF_FFFE, 32'h0);
    wait_done(1'b0, 10, cyc);
    n_cmp++; if (cyc !== 6) begin n_err++; $display("FAIL wrap_cycle: got %0d want 6", cyc); end
    n_cmp++; if (addr_log[2] !== 32'hFFFF_FFFF || addr_log[3] !== 32'h0) begin
      n_err++; $display("FAIL wrap_addr: got %h %h want FFFFFFFF 00000000", addr_log[2], addr_log[3]);
    end
    n_cmp++; if (ma_rdata !== 32'h0403_0201) begin n_err++; $display("FAIL wrap_data: got %h want 04030201", ma_rdata); end
    ma_re = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ma_re = 1'b0; ma_we = 1'b0; ma_width = '0; ma_addr = '0; ma_wdata = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    test_reset;
    test_lw_fetch;
    test_load_ext;
    test_store_half;
    test_contention;
    test_rdy_freeze;
    test_reset_abort;
    test_wrap;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller that shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage load/store path.
- It splits each word, halfword or byte access from the ex/mem pipeline (ma_re/ma_we/ma_width/ma_addr/ma_wdata) into sequential byte transfers.
- It assembles and sign-/zero-extends read data, and raises stall requests toward the pipeline controller until each access completes.

Parameters:
- ADDR_W, 32, width of the RAM byte address; the address increment wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; when low, all state freezes
- if_req  in  1  IF word-fetch request, held high until if_done
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle pulse: if_data valid
- if_data  out  32  fetched instruction, little-endian
- ma_re  in  1  MEM load request, level, held until ma_done
- ma_we  in  1  MEM store request, level, held until ma_done
- ma_width  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ma_addr  in  32  load/store address
- ma_wdata  in  32  store data
- ma_done  out  1  one-cycle pulse: access complete; ma_rdata valid for loads
- ma_rdata  out  32  extended load data
- stallreq_if  out  1  combinational: if_req & ~if_done
- stallreq_mem  out  1  combinational: (ma_re|ma_we) & ~ma_done
- mem_a  out  ADDR_W  RAM byte address
- mem_dout  out  8  RAM write byte
- mem_din  in  8  RAM read byte
- mem_wr  out  1  RAM write strobe

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 (mem_a, mem_dout, mem_wr, if_done, if_data, ma_done, ma_rdata). A reset mid-transfer aborts the transfer immediately; mem_wr drops without waiting for a clock edge.
- rdy=0: state, counters and outputs hold; mem_wr forced 0; no capture.
- States: IDLE, READ, WRITE, DONE. Byte count n = 1 (x00), 2 (x01), 4 otherwise. IF accesses are always n=4.
- IDLE, sampled at a clock edge (cycle 0):
  - MEM request has priority over IF.
  - ma_we dominates ma_re; ma_we -> WRITE, ma_re -> READ(MEM), else if_req -> READ(IF).
  - The owner, base address, n and store data are latched.
- RAM timing: mem_din in cycle c carries the byte for the mem_a driven in cycle c-1.
- READ:
  - Cycles 1..n drive mem_a = base+i, mem_wr=0.
  - The byte for address base+i is captured at the end of cycle i+2 into lane i.
  - After the last capture (end of cycle n+1), enter DONE.
- WRITE:
  - Cycles 1..n drive mem_wr=1, mem_a = base+i, mem_dout = wdata[8i+7:8i].
  - Enter DONE after cycle n.
- DONE (one cycle):
  - The owner's done pulse is high.
  - IF: if_data = assembled word.
  - MEM load: ma_rdata extended per ma_width (B/H sign-extend, BU/HU zero-extend, W as-is).
  - Store: ma_rdata unchanged.
  - Requests are not sampled in DONE; return to IDLE.
- if_data/ma_rdata hold their values until overwritten by the next completion of the same owner.
- Latency: LW 6 cycles, LB 3, SW done in cycle 5, SB in cycle 2. The earliest next acceptance is at the end of the cycle after DONE.
- Transfers are non-preemptible. A request that drops mid-transfer still completes; its done pulse is ignored.
- An IF request arriving during a MEM transfer waits (stallreq_if stays high).
- Invalid ma_width (011, 11x) is treated as word.
- Address wrap at 2^ADDR_W-1 -> 0.

Decomposition:
- Shared defines: funct3 width encodings (LB/LH/LW/LBU/LHU), state encodings, ZeroWord.
- One natural sub-module: mem_ext (combinational byte/half extension by width).

Test Plan:
- LW: if_req, if_addr=0x100, RAM[0x100..0x103]=13,00,00,00 -> mem_a 0x100..0x103 in cycles 1-4, if_done in cycle 6, if_data=0x00000013.
- LB sign: ma_re, width=000, addr=0x20, RAM=0x80 -> ma_done in cycle 3, ma_rdata=0xFFFFFF80. Same access with width=100 -> 0x00000080.
- SH: ma_we, width=001, addr=0x40, wdata=0xDEADBEEF -> mem_wr high cycles 1-2, (0x40,EF) then (0x41,BE), ma_done in cycle 3, RAM[0x42] untouched.
- Contention: if_req and ma_re (LW) asserted in the same cycle -> MEM served first. stallreq_if stays high; IF is accepted after DONE and completes with correct data.
- rdy=0 for 3 cycles mid-SW -> mem_wr=0 while frozen; the transfer resumes at the same byte; the final RAM contents equal wdata.
- rst pulled low during the 2nd byte of a SW -> mem_wr=0 immediately; after rst is released the state is IDLE, and a new LW completes correctly.
